// File: rtl/beat_recorder.sv
// ============================================================================
// Module   : beat_recorder
// Purpose  : Record/playback sequencer feeding the tone generator's ASCII
//            note input; stores (note, duration) runs and replays them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_recorder #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 500000
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [6:0]        key_ascii_i,
  input  logic              key_valid_i,
  input  logic              rec_start_i,
  input  logic              play_start_i,
  input  logic              stop_i,
  output logic [6:0]        ascii_out_o,
  output logic              note_on_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   count_o,
  output logic              rec_full_o,
  output logic              play_done_o
);

  localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam int                CW       = ADDR_W + 1;
  localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
  localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REC   = 2'd1,
    S_FETCH = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e             state_q;
  logic [PRE_W-1:0]   presc_q;
  logic [6:0]         ascii_q;
  logic [6:0]         cur_note_q;
  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   rem_q;
  logic [CW-1:0]      count_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               rec_full_q;
  logic               play_done_q;

  logic [6:0]         mem_note_q [DEPTH];
  logic [DUR_W-1:0]   mem_dur_q  [DEPTH];

  logic [6:0]         live_note;
  logic               tick;
  logic               wr0_en;
  logic               wr1_en;
  logic [6:0]         tick_note_d;
  logic [DUR_W-1:0]   tick_dur_d;
  logic [CW-1:0]      tick_cnt_d;
  logic [CW-1:0]      count_d;

  assign live_note = key_valid_i ? key_ascii_i : 7'd0;
  assign tick      = (presc_q == PRE_MAX);

  // Recording runs in two stages: the tick update first, then a stop flush
  // of whatever run the tick left open, so both may write in one cycle.
  always_comb begin
    wr0_en      = 1'b0;
    tick_note_d = cur_note_q;
    tick_dur_d  = dur_q;
    tick_cnt_d  = count_q;
    if (state_q == S_REC && tick) begin
      if (live_note == cur_note_q && dur_q < DUR_MAX) begin
        tick_dur_d = dur_q + 1'b1;
      end else begin
        if (dur_q != '0) begin
          wr0_en     = 1'b1;
          tick_cnt_d = count_q + 1'b1;
        end
        tick_note_d = live_note;
        tick_dur_d  = DUR_ONE;
      end
    end
    wr1_en  = (state_q == S_REC) && stop_i && (tick_dur_d != '0) &&
              (tick_cnt_d < CNT_FULL);
    count_d = tick_cnt_d + CW'(wr1_en);
  end

  always_ff @(posedge clk_i) begin
    if (wr0_en) begin
      mem_note_q[count_q[ADDR_W-1:0]] <= cur_note_q;
      mem_dur_q[count_q[ADDR_W-1:0]]  <= dur_q;
    end
    if (wr1_en) begin
      mem_note_q[tick_cnt_d[ADDR_W-1:0]] <= tick_note_d;
      mem_dur_q[tick_cnt_d[ADDR_W-1:0]]  <= tick_dur_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      ascii_q     <= '0;
      cur_note_q  <= '0;
      dur_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      rec_full_q  <= 1'b0;
      play_done_q <= 1'b0;
    end else begin
      play_done_q <= 1'b0;
      presc_q     <= tick ? '0 : presc_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          ascii_q <= live_note;
          if (rec_start_i) begin
            state_q    <= S_REC;
            count_q    <= '0;
            rec_full_q <= 1'b0;
            cur_note_q <= live_note;
            dur_q      <= '0;
            presc_q    <= '0;
          end else if (play_start_i) begin
            if (count_q == '0) begin
              play_done_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              idx_q   <= '0;
              presc_q <= '0;
            end
          end
        end
        S_REC: begin
          ascii_q    <= live_note;
          cur_note_q <= tick_note_d;
          dur_q      <= tick_dur_d;
          count_q    <= count_d;
          if (count_d == CNT_FULL) begin
            state_q    <= S_IDLE;
            rec_full_q <= 1'b1;
          end else if (stop_i) begin
            state_q <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (stop_i) begin
            state_q <= S_IDLE;
          end else begin
            ascii_q <= mem_note_q[idx_q];
            rem_q   <= mem_dur_q[idx_q];
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (stop_i) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == DUR_ONE) begin
              if ({1'b0, idx_q} == count_q - 1'b1) begin
                state_q     <= S_IDLE;
                play_done_q <= 1'b1;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= S_FETCH;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ascii_out_o = ascii_q;
  assign note_on_o   = (ascii_q != 7'd0);
  assign state_o     = state_q[1] ? 2'd2 : {1'b0, state_q[0]};
  assign count_o     = count_q;
  assign rec_full_o  = rec_full_q;
  assign play_done_o = play_done_q;

endmodule

`default_nettype wire

// File: doc/beat_recorder.md
Name: beat_recorder

Overview:
Record/playback sequencer that sits directly upstream of the tone generator (rate divider) and drives its 7-bit ASCII note input.
- In IDLE and RECORD it passes the live keyboard note through, so the user hears what they play.
- In RECORD it also stores the note sequence as (note, duration) entries in an internal buffer.
- In PLAY it replays the stored entries with tick-accurate timing.

Parameters:
DEPTH, 64, number of (note, duration) entries in the buffer.
ADDR_W, 6, log2(DEPTH).
DUR_W, 12, duration field width in ticks; max duration = 2^DUR_W-1.
TICK_DIV, 500000, clk cycles per duration tick (10 ms at 50 MHz); must be >=4.

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
key_ascii  in  7  live key ASCII code from the keyboard decoder
key_valid  in  1  high while a key is held
rec_start  in  1  one-cycle pulse: start recording (IDLE only)
play_start  in  1  one-cycle pulse: start playback (IDLE only)
stop  in  1  one-cycle pulse: end record/play (any state)
ascii_out  out  7  note to the rate divider; 0 = rest
note_on  out  1  ascii_out != 0
state  out  2  0 = IDLE, 1 = RECORD, 2 = PLAY
count  out  ADDR_W+1  number of stored entries
rec_full  out  1  sticky: the last recording stopped because the buffer filled
play_done  out  1  one-cycle pulse when playback ends

Behaviour:
- Reset, asynchronous:
  - State is IDLE.
  - ascii_out, note_on, count, rec_full, play_done and all counters are 0.
  - Buffer contents are don't-care.
- Live note: n = key_valid ? key_ascii : 0.
  - In IDLE and RECORD, ascii_out is n registered, so it lags the key by 1 cycle.
- Tick: the prescaler counts 0..TICK_DIV-1 and pulses tick on wrap.
  - The prescaler clears on entry to RECORD or PLAY, so the first tick comes TICK_DIV cycles after entry.
- Command priority in IDLE: rec_start > play_start. Starts are ignored outside IDLE. stop is ignored in IDLE.
- RECORD entry:
  - count <= 0, rec_full <= 0.
  - cur_note <= n, dur <= 0.
- RECORD, on each tick: sample n.
  - If n == cur_note and dur < max: dur++.
  - Otherwise, if dur > 0: write (cur_note, dur) at address count and count++. Then cur_note <= n, dur <= 1.
  - A run longer than max splits into consecutive entries with the same note.
- RECORD, full: on the cycle the write makes count == DEPTH, go to IDLE and set rec_full. No further writes.
- RECORD, stop: flush (cur_note, dur) if dur > 0 and count < DEPTH, then go to IDLE the same cycle.
  - If stop and tick coincide, process the tick first, then the flush.
- PLAY entry:
  - If count == 0: pulse play_done next cycle and stay in IDLE.
  - Otherwise idx <= 0 and go to FETCH.
- FETCH (internal sub-state, 1 cycle):
  - Synchronous buffer read of entry idx.
  - ascii_out holds its previous value, so there is no glitch.
- HOLD:
  - ascii_out <= entry note and rem <= entry duration.
  - Each tick, rem--.
  - When rem reaches 0: if idx == count-1, go to IDLE and pulse play_done; otherwise idx++ and go to FETCH.
- Playback timing:
  - The prescaler runs continuously through FETCH, so total play time = sum(durations) x TICK_DIV cycles, ±2 cycles of fetch skew.
  - Note boundaries fall within 2 cycles after the corresponding tick.
- stop in PLAY: go to IDLE next cycle. ascii_out returns to live n one cycle later. No play_done pulse.
- count and buffer contents are preserved across PLAY and IDLE; only rec_start clears count.
- note_on is combinationally derived from registered ascii_out.

Test Plan:
All scenarios use TICK_DIV=4, DUR_W=4, DEPTH=4; key changes are applied mid-way between ticks.
1. Assert resetn low asynchronously mid-cycle -> ascii_out=0, note_on=0, state=0, count=0, rec_full=0 immediately.
2. rec_start; hold 'A' (65) for 3 ticks, release for 2 ticks, hold 'S' (83) for 2 ticks; stop.
   -> count=3, entries (65,3), (0,2), (83,2).
   Then play_start -> ascii_out=65 for 12±2 cycles, 0 for 8±2, 83 for 8±2; play_done pulses once; state=0.
3. rec_start; hold 'D' (68) for 20 ticks; stop -> entries (68,15), (68,5); count=2.
4. rec_start; play 5 alternating 1-tick segments (70, 0, 71, 0, 72) -> after the 4th write state=0, rec_full=1, count=4; 72 never stored.
5. After reset, play_start -> play_done pulses within 2 cycles; ascii_out stays 0; state never equals 2.
6. rec_start and play_start in the same cycle -> state=1.
   Drop resetn mid-playback of scenario 2 -> ascii_out=0 and count=0 immediately.
